// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared widths, kernel weights and scan state encoding for conv_window_mac
package conv_pkg;

    localparam int ADDR_W = 14;
    localparam int BYTE_W = 8;
    localparam int TAPS   = 9;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_MAC   = 3'd3,
        ST_WRITE = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    // Weight k multiplies window slot k (win_data bits [8k+7:8k]).
    function automatic logic signed [BYTE_W-1:0] kernel_weight(input logic [3:0] k);
        case (k)
            4'd0:    return 8'sd1;
            4'd1:    return 8'sd2;
            4'd2:    return 8'sd1;
            4'd3:    return 8'sd2;
            4'd4:    return 8'sd4;
            4'd5:    return 8'sd2;
            4'd6:    return 8'sd1;
            4'd7:    return 8'sd2;
            4'd8:    return 8'sd1;
            default: return 8'sd0;
        endcase
    endfunction

endpackage

// File: rtl/conv_mac_unit.sv
// rtl/conv_mac_unit.sv - 9-tap sequential MAC with bias, ReLU, shift and saturate
module conv_mac_unit
    import conv_pkg::*;
#(
    parameter int                      ACC_W = 20,
    parameter int                      OUT_W = 16,
    parameter int                      SHIFT = 4,
    parameter logic signed [ACC_W-1:0] BIAS  = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     step,
    input  logic [BYTE_W-1:0]        data_byte,
    input  logic signed [BYTE_W-1:0] weight,
    output logic [3:0]               tap,
    output logic                     last_tap,
    output logic [OUT_W-1:0]         result
);

    localparam int PROD_W = 2 * BYTE_W + 1;
    localparam int WIDE_W = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  acc_sum;
    logic signed [ACC_W-1:0]  biased;
    logic signed [ACC_W-1:0]  shifted;
    logic [WIDE_W-1:0]        shifted_w;
    logic [WIDE_W-1:0]        max_w;

    assign last_tap = (tap == 4'(TAPS - 1));

    // Result already includes the tap presented this cycle, so the caller latches it on the last step.
    always_comb begin
        prod      = $signed({1'b0, data_byte}) * weight;
        prod_ext  = ACC_W'(prod);
        acc_sum   = acc + prod_ext;
        biased    = acc_sum + BIAS;
        shifted   = biased[ACC_W-1] ? '0 : (biased >>> SHIFT);
        shifted_w = WIDE_W'($unsigned(shifted));
        max_w     = WIDE_W'({OUT_W{1'b1}});
        result    = (shifted_w > max_w) ? {OUT_W{1'b1}} : shifted_w[OUT_W-1:0];
    end

    // Accumulate one tap per step; clear restarts the window.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            acc <= '0;
            tap <= '0;
        end else if (step) begin
            acc <= acc_sum;
            tap <= last_tap ? 4'd0 : tap + 4'd1;
        end
    end

endmodule

// File: rtl/conv_window_mac.sv
// rtl/conv_window_mac.sv - raster scan of the image, one window fetch and one convolution result per pixel
module conv_window_mac
    import conv_pkg::*;
#(
    parameter int                      IMG_W = 128,
    parameter int                      ACC_W = 20,
    parameter int                      OUT_W = 16,
    parameter int                      SHIFT = 4,
    parameter logic signed [ACC_W-1:0] BIAS  = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ready,
    output logic                     busy,
    output logic                     done,
    output logic                     win_start,
    output logic [ADDR_W-1:0]        win_addr,
    input  logic                     win_finish,
    input  logic [TAPS*BYTE_W-1:0]   win_data,
    output logic                     o_we,
    output logic [ADDR_W-1:0]        o_addr,
    output logic [OUT_W-1:0]         o_data
);

    localparam int                 COORD_W = ADDR_W / 2;
    localparam logic [COORD_W-1:0] LAST    = COORD_W'(IMG_W - 1);

    state_t                   state;
    logic [COORD_W-1:0]       row;
    logic [COORD_W-1:0]       col;
    logic [TAPS*BYTE_W-1:0]   win_bytes;
    logic                     mac_clear;
    logic                     mac_step;
    logic                     last_tap;
    logic [3:0]               tap;
    logic [BYTE_W-1:0]        cur_byte;
    logic signed [BYTE_W-1:0] cur_weight;
    logic [OUT_W-1:0]         mac_result;
    logic                     at_last_pos;

    assign win_addr    = {row, col};
    assign at_last_pos = (row == LAST) && (col == LAST);
    assign mac_clear   = (state == ST_WAIT) && win_finish;
    assign mac_step    = (state == ST_MAC);
    assign cur_byte    = win_bytes[int'(tap) * BYTE_W +: BYTE_W];
    assign cur_weight  = kernel_weight(tap);

    conv_mac_unit #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT),
        .BIAS  (BIAS)
    ) u_mac (
        .clk       (clk),
        .rst       (rst),
        .clear     (mac_clear),
        .step      (mac_step),
        .data_byte (cur_byte),
        .weight    (cur_weight),
        .tap       (tap),
        .last_tap  (last_tap),
        .result    (mac_result)
    );

    // Scan FSM: request, capture, MAC, write, advance; all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            row       <= '0;
            col       <= '0;
            win_bytes <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            win_start <= 1'b0;
            o_we      <= 1'b0;
            o_addr    <= '0;
            o_data    <= '0;
        end else begin
            win_start <= 1'b0;
            o_we      <= 1'b0;
            done      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (ready) begin
                        row       <= '0;
                        col       <= '0;
                        busy      <= 1'b1;
                        win_start <= 1'b1;
                        state     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (win_finish) begin
                        win_bytes <= win_data;
                        state     <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    if (last_tap) begin
                        o_we   <= 1'b1;
                        o_addr <= {row, col};
                        o_data <= mac_result;
                        state  <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (at_last_pos) begin
                        row   <= '0;
                        col   <= '0;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_DONE;
                    end else begin
                        if (col == LAST) begin
                            col <= '0;
                            row <= row + COORD_W'(1);
                        end else begin
                            col <= col + COORD_W'(1);
                        end
                        win_start <= 1'b1;
                        state     <= ST_REQ;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_window_mac.sv
// tb/tb_conv_window_mac.sv - directed self-checking bench for conv_window_mac on an 8x8 image
module tb_conv_window_mac;

    localparam int IMG    = 8;
    localparam int NPOS   = IMG * IMG;
    localparam int BIAS_B = -2000;

    logic        clk = 1'b0;
    logic        rst;
    logic        ready;
    logic        win_finish;
    logic [71:0] win_data;

    logic        busy, done, win_start, o_we;
    logic [13:0] win_addr, o_addr;
    logic [15:0] o_data;

    logic        b_busy, b_done, b_win_start, b_o_we;
    logic [13:0] b_win_addr, b_o_addr;
    logic [15:0] b_o_data;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  img [IMG][IMG];
    logic [15:0] got_data [NPOS];
    logic [15:0] got_b    [NPOS];

    always #5 clk = ~clk;

    conv_window_mac #(
        .IMG_W (IMG)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .ready      (ready),
        .busy       (busy),
        .done       (done),
        .win_start  (win_start),
        .win_addr   (win_addr),
        .win_finish (win_finish),
        .win_data   (win_data),
        .o_we       (o_we),
        .o_addr     (o_addr),
        .o_data     (o_data)
    );

    conv_window_mac #(
        .IMG_W (IMG),
        .BIAS  (20'(BIAS_B))
    ) u_dut_b (
        .clk        (clk),
        .rst        (rst),
        .ready      (ready),
        .busy       (b_busy),
        .done       (b_done),
        .win_start  (b_win_start),
        .win_addr   (b_win_addr),
        .win_finish (win_finish),
        .win_data   (win_data),
        .o_we       (b_o_we),
        .o_addr     (b_o_addr),
        .o_data     (b_o_data)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [71:0] make_window(input int r, input int c);
        logic [71:0] w = '0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                int rr = r + dr;
                int cc = c + dc;
                int k  = (dr + 1) * 3 + (dc + 1);
                if (rr >= 0 && rr < IMG && cc >= 0 && cc < IMG) w[8*k +: 8] = img[rr][cc];
            end
        end
        return w;
    endfunction

    function automatic int model(input logic [71:0] w, input int bias);
        int wt [9] = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
        int s = bias;
        int r;
        for (int k = 0; k < 9; k++) s += int'(w[8*k +: 8]) * wt[k];
        if (s < 0) r = 0;
        else r = s >>> 4;
        if (r > 65535) r = 65535;
        return r;
    endfunction

    task automatic fill(input int mode);
        for (int r = 0; r < IMG; r++)
            for (int c = 0; c < IMG; c++)
                img[r][c] = (mode < 0) ? 8'($urandom_range(0, 255)) : 8'(mode);
    endtask

    task automatic issue_window(input int extra, output logic [13:0] a, output logic [71:0] w);
        int   n = 0;
        logic stable = 1'b1;
        while (win_start !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check("win_start_seen", 32'(win_start), 1);
        a = win_addr;
        w = make_window(int'(a[13:7]), int'(a[6:0]));
        tick();
        check("win_start_one_cycle", 32'(win_start), 0);
        if (extra > 0) begin
            repeat (extra) begin
                if (win_addr !== a) stable = 1'b0;
                tick();
            end
            if (win_addr !== a) stable = 1'b0;
            check("win_addr_stable", 32'(stable), 1);
        end
        win_finish = 1'b1;
        win_data   = w;
        tick();
        win_finish = 1'b0;
        win_data   = 72'({$urandom, $urandom, $urandom});
    endtask

    task automatic collect_write(input bit spurious, input bit check_lat, input logic [13:0] a,
                                 input logic [71:0] w, output logic [15:0] d, output logic [15:0] db);
        int lat = 1;
        while (o_we !== 1'b1 && lat < 40) begin
            if (spurious && lat == 3) begin
                win_finish = 1'b1;
                win_data   = ~w;
            end else begin
                win_finish = 1'b0;
            end
            tick();
            lat++;
        end
        win_finish = 1'b0;
        if (check_lat) check("we_latency", 32'(lat), 10);
        check("we_seen", 32'(o_we), 1);
        check("b_we_seen", 32'(b_o_we), 1);
        check("o_addr", 32'(o_addr), 32'(a));
        check("o_data", 32'(o_data), 32'(model(w, 0)));
        check("b_o_data", 32'(b_o_data), 32'(model(w, BIAS_B)));
        d  = o_data;
        db = b_o_data;
        tick();
        check("we_one_cycle", 32'(o_we), 0);
    endtask

    task automatic scan(input int delay_pos, input int spur_pos, input int ready_pos);
        logic [13:0] a;
        logic [71:0] w;
        logic [15:0] d, db;
        ready = 1'b1;
        tick();
        ready = 1'b0;
        for (int i = 0; i < NPOS; i++) begin
            if (i == ready_pos) ready = 1'b1;
            issue_window((i == delay_pos) ? 50 : 0, a, w);
            ready = 1'b0;
            check("scan_addr", 32'(a), 32'({7'(i / IMG), 7'(i % IMG)}));
            collect_write(i == spur_pos, (i == delay_pos) || (i == 0), a, w, d, db);
            got_data[i] = d;
            got_b[i]    = db;
            check("done_timing", 32'(done), 32'(i == NPOS - 1));
            check("busy_during_scan", 32'(busy), 32'(i != NPOS - 1));
        end
        tick();
        check("done_one_cycle", 32'(done), 0);
        check("busy_after_scan", 32'(busy), 0);
    endtask

    initial begin
        logic [13:0] a;
        logic [71:0] w;
        logic [15:0] d, db;
        logic        seen;

        rst        = 1'b1;
        ready      = 1'b0;
        win_finish = 1'b0;
        win_data   = '0;
        repeat (3) tick();
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_win_start", 32'(win_start), 0);
        check("rst_win_addr", 32'(win_addr), 0);
        check("rst_o_we", 32'(o_we), 0);
        check("rst_o_addr", 32'(o_addr), 0);
        check("rst_o_data", 32'(o_data), 0);
        rst = 1'b0;
        repeat (3) tick();
        check("idle_without_ready", 32'(busy), 0);

        fill(100);
        scan(45, 46, 10);
        check("c100_corner", 32'(got_data[0]), 56);
        check("c100_edge_r5c0", 32'(got_data[40]), 75);
        check("c100_interior_r5c5", 32'(got_data[45]), 100);
        check("c100_spurious_r5c6", 32'(got_data[46]), 100);
        check("c100_bias_relu", 32'(got_b[45]), 0);
        check("c100_bias_corner", 32'(got_b[0]), 0);

        fill(255);
        scan(-1, -1, -1);
        check("c255_interior", 32'(got_data[45]), 255);
        check("c255_bias_interior", 32'(got_b[45]), 130);
        check("c255_bias_corner", 32'(got_b[0]), 18);
        check("c255_bias_edge", 32'(got_b[40]), 66);

        fill(-1);
        scan(-1, 20, 30);

        ready = 1'b1;
        tick();
        ready = 1'b0;
        for (int i = 0; i < 37; i++) begin
            issue_window(0, a, w);
            collect_write(1'b0, 1'b0, a, w, d, db);
        end
        issue_window(0, a, w);
        check("pos37_addr", 32'(a), 32'({7'd4, 7'd5}));
        repeat (4) tick();
        check("pre_reset_busy", 32'(busy), 1);
        rst = 1'b1;
        tick();
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        check("abort_win_start", 32'(win_start), 0);
        check("abort_win_addr", 32'(win_addr), 0);
        check("abort_o_we", 32'(o_we), 0);
        check("abort_o_addr", 32'(o_addr), 0);
        check("abort_o_data", 32'(o_data), 0);
        rst  = 1'b0;
        seen = 1'b0;
        repeat (20) begin
            if (o_we || win_start || busy) seen = 1'b1;
            tick();
        end
        check("quiet_after_abort", 32'(seen), 0);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        issue_window(0, a, w);
        check("restart_addr", 32'(a), 0);
        collect_write(1'b0, 1'b1, a, w, d, db);
        check("restart_o_addr", 32'(o_addr), 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
